// File: rtl/servo_pwm_pkg.sv
// rtl/servo_pwm_pkg.sv - shared types and pulse-width helpers for servo PWM
// Purpose : pulse_t default type plus the center/clamp/slew helper functions
//           used by every servo channel. Helpers work on 32-bit unsigned values
//           so any CNT_W up to 31 fits, with one spare bit for step arithmetic.
// Ports   : none (package)
package servo_pwm_pkg;

   localparam int DEF_CNT_W = 21;

   typedef logic [DEF_CNT_W-1:0] pulse_t;
   typedef logic [31:0]          wide_t;

   function automatic wide_t center(input wide_t min_p, input wide_t max_p);
      return (min_p + max_p) >> 1;
   endfunction

   function automatic wide_t clamp(input wide_t v, input wide_t min_p, input wide_t max_p);
      if (v < min_p)
         return min_p;
      else if (v > max_p)
         return max_p;
      else
         return v;
   endfunction

   // Move act toward tgt by at most step; step==0 means jump straight to tgt.
   function automatic wide_t step_toward(input wide_t act, input wide_t tgt, input wide_t step);
      wide_t diff;
      if (step == '0)
         return tgt;
      if (tgt >= act) begin
         diff = tgt - act;
         return act + ((diff > step) ? step : diff);
      end
      diff = act - tgt;
      return act - ((diff > step) ? step : diff);
   endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// rtl/servo_pwm_multi_if.sv - target-width write bus for servo_pwm_multi
// Purpose : groups the CPU-side target write strobe, channel index and width.
// Ports   : wr_en    one-cycle write strobe
//           wr_ch    channel index (at least 1 bit)
//           wr_pulse requested pulse width in ticks
//           master drives the bus, slave (the PWM block) receives it.
interface servo_pwm_multi_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 21
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [CNT_W-1:0] wr_pulse;

   modport master (output wr_en, output wr_ch, output wr_pulse);
   modport slave  (input  wr_en, input  wr_ch, input  wr_pulse);
endinterface

// File: rtl/servo_slew_channel.sv
// rtl/servo_slew_channel.sv - one servo channel: target, slewed active width, PWM compare
// Purpose : holds the clamped target and the slew-limited active width, and
//           produces the registered PWM level and at-target flag.
// Ports   : clk, reset    clock, synchronous active-high reset
//           enable        pulse generation enable
//           boundary      one-cycle strobe on the last tick of a period
//           wr, wr_pulse  target write for this channel
//           count         shared period counter
//           pwm           registered PWM output
//           at_target     registered (active == target)
module servo_slew_channel
   import servo_pwm_pkg::*;
#(
   parameter int CNT_W     = 21,
   parameter int MIN_PULSE = 100000,
   parameter int MAX_PULSE = 200000,
   parameter int SLEW_STEP = 5555
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             boundary,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_pulse,
   input  logic [CNT_W-1:0] count,
   output logic             pwm,
   output logic             at_target
);
   localparam wide_t MIN_W    = wide_t'(MIN_PULSE);
   localparam wide_t MAX_W    = wide_t'(MAX_PULSE);
   localparam wide_t STEP_W   = wide_t'(SLEW_STEP);
   localparam logic [CNT_W-1:0] CENTER = CNT_W'(center(MIN_W, MAX_W));

   logic [CNT_W-1:0] target, active;
   logic [CNT_W-1:0] target_nxt, active_nxt;

   // The step reads the current target register, so a write landing on the
   // boundary cycle only takes effect from the following boundary.
   always_comb begin
      target_nxt = target;
      active_nxt = active;
      if (wr)
         target_nxt = CNT_W'(clamp(wide_t'(wr_pulse), MIN_W, MAX_W));
      if (boundary)
         active_nxt = CNT_W'(step_toward(wide_t'(active), wide_t'(target), STEP_W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         target    <= CENTER;
         active    <= CENTER;
         pwm       <= 1'b0;
         at_target <= 1'b1;
      end else begin
         target    <= target_nxt;
         active    <= active_nxt;
         pwm       <= enable && (count < active);
         at_target <= (active_nxt == target_nxt);
      end
   end

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with slew limiting
// Purpose : one shared period counter drives NUM_CH servo channels; targets are
//           written over the bus, clamped, and approached at period boundaries.
// Ports   : clk, reset      clock, synchronous active-high reset
//           enable          1 = generate pulses, 0 = outputs low, counter parked
//           bus             target write bus (slave side)
//           pwm_o           registered PWM pins
//           period_start_o  registered pulse aligned with the PWM rising edge
//           at_target_o     per channel, active width equals target
module servo_pwm_multi
   import servo_pwm_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int CNT_W        = 21,
   parameter int PERIOD_TICKS = 2000000,
   parameter int MIN_PULSE    = 100000,
   parameter int MAX_PULSE    = 200000,
   parameter int SLEW_STEP    = 5555
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   servo_pwm_multi_if.slave    bus,
   output logic [NUM_CH-1:0]   pwm_o,
   output logic                period_start_o,
   output logic [NUM_CH-1:0]   at_target_o
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_TICKS - 1);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("servo_pwm_multi: NUM_CH must be at least 1");
   end
   if (CNT_W > 31) begin : g_bad_cnt_w
      $error("servo_pwm_multi: CNT_W must not exceed 31");
   end
   if (MAX_PULSE >= PERIOD_TICKS) begin : g_bad_max
      $error("servo_pwm_multi: MAX_PULSE must be below PERIOD_TICKS");
   end
   if (MIN_PULSE > MAX_PULSE) begin : g_bad_min
      $error("servo_pwm_multi: MIN_PULSE must not exceed MAX_PULSE");
   end
   if (longint'(PERIOD_TICKS) > (longint'(1) << CNT_W)) begin : g_bad_period
      $error("servo_pwm_multi: PERIOD_TICKS does not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] count;
   logic             boundary;

   assign boundary = enable && (count == LAST);

   // Parked at zero while disabled so re-enabling always starts a fresh period.
   always_ff @(posedge clk) begin
      if (reset || !enable)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         period_start_o <= 1'b0;
      else
         period_start_o <= enable && (count == '0);
   end

   // Indices at or above NUM_CH match no channel, so such writes drop silently.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = bus.wr_en && (bus.wr_ch == CH_W'(i));

      servo_slew_channel #(
         .CNT_W     (CNT_W),
         .MIN_PULSE (MIN_PULSE),
         .MAX_PULSE (MAX_PULSE),
         .SLEW_STEP (SLEW_STEP)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .enable    (enable),
         .boundary  (boundary),
         .wr        (sel),
         .wr_pulse  (bus.wr_pulse),
         .count     (count),
         .pwm       (pwm_o[i]),
         .at_target (at_target_o[i])
      );
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - self-checking bench for servo_pwm_multi
module tb_servo_pwm_multi;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 21;
   localparam int P      = 100;
   localparam int MINP   = 10;
   localparam int MAXP   = 20;
   localparam int STEP   = 3;
   localparam int CENTER = (MINP + MAXP) / 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic [NUM_CH-1:0] pwm_o, at_target_o;
   logic period_start_o;

   int total = 0;
   int bad = 0;

   int m_cnt;
   int m_tgt[NUM_CH];
   int m_act[NUM_CH];
   logic [NUM_CH-1:0] exp_pwm;
   logic [NUM_CH-1:0] exp_at;
   logic exp_ps;

   servo_pwm_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   servo_pwm_multi #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_TICKS(P),
      .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SLEW_STEP(STEP)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus),
      .pwm_o(pwm_o), .period_start_o(period_start_o), .at_target_o(at_target_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clampi(input int v);
      return (v < MINP) ? MINP : ((v > MAXP) ? MAXP : v);
   endfunction

   function automatic int slew(input int act, input int tgt);
      int d;
      d = (tgt > act) ? tgt - act : act - tgt;
      if (STEP != 0 && d > STEP) d = STEP;
      return (tgt > act) ? act + d : act - d;
   endfunction

   // Abstract reference: what one clock edge does to the servo state.
   task automatic model_edge();
      int nt[NUM_CH];
      int na[NUM_CH];
      bit bnd;
      if (reset) begin
         m_cnt = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_tgt[i] = CENTER;
            m_act[i] = CENTER;
         end
         exp_pwm = '0;
         exp_ps  = 1'b0;
         exp_at  = '1;
      end else begin
         bnd = enable && (m_cnt == P - 1);
         for (int i = 0; i < NUM_CH; i++) nt[i] = m_tgt[i];
         if (bus.wr_en && int'(bus.wr_ch) < NUM_CH)
            nt[bus.wr_ch] = clampi(int'(bus.wr_pulse));
         for (int i = 0; i < NUM_CH; i++) begin
            exp_pwm[i] = enable && (m_cnt < m_act[i]);
            na[i] = bnd ? slew(m_act[i], m_tgt[i]) : m_act[i];
            exp_at[i] = (na[i] == nt[i]);
         end
         exp_ps = enable && (m_cnt == 0);
         m_cnt = enable ? (m_cnt + 1) % P : 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_tgt[i] = nt[i];
            m_act[i] = na[i];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("pwm", 32'(pwm_o), 32'(exp_pwm));
      chk("pstart", 32'(period_start_o), 32'(exp_ps));
      chk("at_tgt", 32'(at_target_o), 32'(exp_at));
   endtask

   task automatic wait_ps(output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!period_start_o && waited < 3 * P);
      chk("ps_found", 32'(period_start_o), 32'd1);
   endtask

   // Measure one full period starting at the period_start tick; optionally
   // write (ch,val) on the edge that samples count==wr_at.
   task automatic measure(input int wr_at, input int ch, input int val,
                          output int w0, output int w1, output int waited);
      wait_ps(waited);
      w0 = int'(pwm_o[0]);
      w1 = int'(pwm_o[1]);
      for (int j = 1; j < P; j++) begin
         if (j == wr_at) begin
            bus.wr_en    = 1'b1;
            bus.wr_ch    = 1'(ch);
            bus.wr_pulse = CNT_W'(val);
         end
         tick();
         bus.wr_en = 1'b0;
         w0 += int'(pwm_o[0]);
         w1 += int'(pwm_o[1]);
      end
   endtask

   initial begin
      int w0, w1, wt;
      int seq[$];
      bus.wr_en = 1'b0;
      bus.wr_ch = '0;
      bus.wr_pulse = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_at", 32'(at_target_o), 32'd3);
      chk("rst_pwm", 32'(pwm_o), 32'd0);
      reset = 1'b0;
      enable = 1'b1;

      // Center width on both channels, 100-cycle period
      measure(-1, 0, 0, w0, w1, wt);
      chk("w0_center", w0, CENTER);
      chk("w1_center", w1, CENTER);
      measure(-1, 0, 0, w0, w1, wt);
      chk("period_gap", wt, 1);

      // Mid-period write on ch0, slewing 15 -> 18 -> 20
      measure(50, 0, 20, w0, w1, wt);
      chk("s2_cur", w0, 15);
      chk("s2_at0_a", 32'(at_target_o[0]), 0);
      measure(-1, 0, 0, w0, w1, wt);
      chk("s2_p1", w0, 18);
      chk("s2_at0_b", 32'(at_target_o[0]), 1);
      measure(-1, 0, 0, w0, w1, wt);
      chk("s2_p2", w0, 20);
      chk("s2_ch1", w1, 15);

      // Clamping on ch1: 3 -> 10, then 50 -> 20
      seq = '{15, 12, 10};
      foreach (seq[k]) begin
         measure(k == 0 ? 50 : -1, 1, 3, w0, w1, wt);
         chk("s3_lo", w1, seq[k]);
      end
      seq = '{10, 13, 16, 19, 20};
      foreach (seq[k]) begin
         measure(k == 0 ? 50 : -1, 1, 50, w0, w1, wt);
         chk("s3_hi", w1, seq[k]);
      end

      // Write on the boundary edge: step uses the old target first
      seq = '{20, 20, 17, 14, 11, 10};
      foreach (seq[k]) begin
         measure(k == 0 ? P - 1 : -1, 0, 10, w0, w1, wt);
         chk("s4_bnd", w0, seq[k]);
      end

      // Drop enable mid-pulse, then re-enable
      wait_ps(wt);
      repeat (4) tick();
      enable = 1'b0;
      tick();
      chk("s5_pwm_off", 32'(pwm_o), 0);
      repeat (10) tick();
      chk("s5_no_ps", 32'(period_start_o), 0);
      enable = 1'b1;
      measure(-1, 0, 0, w0, w1, wt);
      chk("s5_restart", wt, 1);
      chk("s5_w0", w0, 10);
      chk("s5_w1", w1, 20);

      // Reset in the middle of an 18-wide pulse
      seq = '{10, 13, 16};
      foreach (seq[k]) begin
         measure(k == 0 ? 50 : -1, 0, 18, w0, w1, wt);
         chk("s6_ramp", w0, seq[k]);
      end
      wait_ps(wt);
      repeat (7) tick();
      reset = 1'b1;
      tick();
      chk("s6_pwm_low", 32'(pwm_o), 0);
      chk("s6_at", 32'(at_target_o), 3);
      reset = 1'b0;
      measure(-1, 0, 0, w0, w1, wt);
      chk("s6_w0", w0, CENTER);
      chk("s6_w1", w1, CENTER);
      chk("s6_at_after", 32'(at_target_o), 3);

      // Random traffic against the reference model
      for (int n = 0; n < 4000; n++) begin
         bus.wr_en    = ($urandom_range(0, 9) == 0);
         bus.wr_ch    = 1'($urandom_range(0, 1));
         bus.wr_pulse = CNT_W'($urandom_range(0, 40));
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      bus.wr_en = 1'b0;
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
